// File: rtl/cache_burst_pkg.sv
// Shared sizes and state encoding for the cache burst responder.
package cache_burst_pkg;

  localparam int BURST_LEN = 4;
  localparam int WORD_W    = 16;
  localparam int IDX_W     = $clog2(BURST_LEN);

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam idx_t LAST_IDX = idx_t'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    FILL,
    WR_ISSUE,
    WR_WAIT,
    WR_DONE
  } state_e;

endpackage

// File: rtl/burst_buffer.sv
// Line buffer: one write port, one combinational read port.
module burst_buffer
  import cache_burst_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [WORD_W-1:0] rdata
);

  word_t mem_q [BURST_LEN];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/cache_burst_responder.sv
// Serves cache line fills (4-word bursts) and single-word writes
// from a word-wide backing memory with an ack handshake.
module cache_burst_responder
  import cache_burst_pkg::*;
#(
  parameter int ADDR_BITS = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sdram_req,
  input  logic                 sdram_rw,
  input  logic [31:0]          sdram_addr,
  input  logic [WORD_W-1:0]    data_to_sdram,
  output logic [WORD_W-1:0]    data_from_sdram,
  output logic                 sdram_fill,
  output logic                 sdram_wack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-2:0] mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  input  logic [WORD_W-1:0]    mem_rdata,
  input  logic                 mem_ack
);

  localparam int AW = ADDR_BITS - 1;

  state_e            state_q, state_d;
  idx_t              idx_q, idx_d;
  logic [AW-1:0]     addr_q, addr_d;
  word_t             wdata_q, wdata_d;
  word_t             rdata_q, rdata_d;
  logic              fill_q, fill_d;
  logic              wack_q, wack_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [AW-1:0]     maddr_q, maddr_d;
  word_t             mwdata_q, mwdata_d;
  logic              buf_we;
  word_t             buf_rdata;

  // Byte-lane bit and bits above the memory window are not forwarded.
  logic unused_addr;
  assign unused_addr = ^{sdram_addr[31:ADDR_BITS], sdram_addr[0]};

  burst_buffer u_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (idx_q),
    .wdata (mem_rdata),
    .ridx  (idx_q),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fill_d   = 1'b0;
    wack_d   = 1'b0;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    buf_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (sdram_req) begin
          addr_d  = sdram_addr[ADDR_BITS-1:1];
          wdata_d = data_to_sdram;
          state_d = sdram_rw ? RD_ISSUE : WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        mreq_d  = 1'b1;
        mwe_d   = 1'b0;
        maddr_d = {addr_q[AW-1:IDX_W], idx_q};
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_ack) begin
          buf_we = 1'b1;
          mreq_d = 1'b0;
          idx_d  = idx_q + 1'b1;
          state_d = (idx_q == LAST_IDX) ? FILL : RD_ISSUE;
        end
      end
      FILL: begin
        rdata_d = buf_rdata;
        fill_d  = (idx_q == '0);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      WR_ISSUE: begin
        mreq_d   = 1'b1;
        mwe_d    = 1'b1;
        maddr_d  = addr_q;
        mwdata_d = wdata_q;
        state_d  = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_ack) begin
          mreq_d  = 1'b0;
          wack_d  = 1'b1;
          state_d = WR_DONE;
        end
      end
      // Hold here so a still-asserted request is not serviced twice.
      WR_DONE: begin
        if (!sdram_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fill_q   <= 1'b0;
      wack_q   <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fill_q   <= fill_d;
      wack_q   <= wack_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign data_from_sdram = rdata_q;
  assign sdram_fill      = fill_q;
  assign sdram_wack      = wack_q;
  assign mem_req         = mreq_q;
  assign mem_we          = mwe_q;
  assign mem_addr        = maddr_q;
  assign mem_wdata       = mwdata_q;

endmodule

// File: tb/tb_cache_burst_responder.sv
// Scoreboard bench: cache/memory models, queued expectations, monitors.
module tb_cache_burst_responder;

  localparam int AB = 26;

  typedef struct packed {
    logic          we;
    logic [AB-2:0] addr;
    logic [15:0]   data;
  } mreq_t;

  typedef logic [3:0][15:0] line_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sdram_req = 1'b0;
  logic          sdram_rw = 1'b0;
  logic [31:0]   sdram_addr = '0;
  logic [15:0]   data_to_sdram = '0;
  logic [15:0]   data_from_sdram;
  logic          sdram_fill;
  logic          sdram_wack;
  logic          mem_req;
  logic          mem_we;
  logic [AB-2:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_ack;

  int          checks = 0;
  int          errors = 0;
  mreq_t       exp_mem[$];
  line_t       exp_fill[$];
  int          exp_wack = 0;
  logic [15:0] exp_hold = '0;
  logic [15:0] store[int];
  logic [15:0] model_mem[int];
  int          lat_fixed = 2;
  bit          slow_w2 = 1'b0;
  bit          spurious = 1'b0;

  always #5 clk = ~clk;

  cache_burst_responder #(.ADDR_BITS(AB)) dut (
    .clk             (clk),
    .reset           (reset),
    .sdram_req       (sdram_req),
    .sdram_rw        (sdram_rw),
    .sdram_addr      (sdram_addr),
    .data_to_sdram   (data_to_sdram),
    .data_from_sdram (data_from_sdram),
    .sdram_fill      (sdram_fill),
    .sdram_wack      (sdram_wack),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int w);
    return 16'(w * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] model_rd(input int w);
    return model_mem.exists(w) ? model_mem[w] : init_word(w);
  endfunction

  function automatic logic [15:0] store_rd(input int w);
    return store.exists(w) ? store[w] : init_word(w);
  endfunction

  // Backing memory: acks after a chosen latency, checks each request.
  initial begin : responder
    bit            busy = 1'b0;
    int            cnt = 0;
    int            lat = 0;
    logic [AB-2:0] cur_addr = '0;
    logic          cur_we = 1'b0;
    mreq_t         e;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        busy = 1'b0;
        if (spurious) begin
          spurious = 1'b0;
          mem_ack = 1'b1;
          mem_rdata = 16'hDEAD;
        end
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
          cur_addr = mem_addr;
          cur_we = mem_we;
          lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
          if (slow_w2 && !mem_we && mem_addr[1:0] == 2'd2) lat = 50;
          if (exp_mem.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected mem_req: addr 0x%0h we %0b, none expected",
                     mem_addr, mem_we);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", mem_wdata, e.data);
          end
        end else begin
          chk("mem_req_hold", {mem_we, mem_addr}, {cur_we, cur_addr});
        end
        if (cnt == lat) begin
          mem_ack = 1'b1;
          busy = 1'b0;
          if (mem_we) store[int'(mem_addr)] = mem_wdata;
          else mem_rdata = store_rd(int'(mem_addr));
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin : fill_monitor
    line_t ln;
    forever begin
      @(negedge clk);
      if (sdram_fill) begin
        if (exp_fill.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected fill: data 0x%0h, no fill expected",
                   data_from_sdram);
        end else begin
          ln = exp_fill.pop_front();
          exp_hold = ln[3];
          chk("fill_w0", data_from_sdram, ln[0]);
          for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("fill_w%0d", k), data_from_sdram, ln[k]);
            chk("fill_pulse_once", sdram_fill, 1'b0);
          end
        end
      end
    end
  end

  initial begin : wack_monitor
    forever begin
      @(negedge clk);
      if (sdram_wack) begin
        chk("wack_expected", exp_wack > 0, 1'b1);
        if (exp_wack > 0) exp_wack--;
      end
    end
  end

  initial begin : fill_guard
    int ph = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ph = 0;
      end else if (sdram_fill || ph > 0) begin
        chk("no_mem_req_in_fill", mem_req, 1'b0);
        ph = sdram_fill ? 3 : ph - 1;
      end else begin
        chk("data_hold", data_from_sdram, exp_hold);
      end
    end
  end

  task automatic wait_for(input int which, input int budget, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      case (which)
        0:       hit = mem_req;
        1:       hit = sdram_fill;
        default: hit = sdram_wack;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: no event in %0d cycles, event required",
               name, budget);
    end
  endtask

  task automatic push_read(input logic [31:0] a);
    logic [AB-2:0] w = a[AB-1:1];
    logic [AB-2:0] wi;
    line_t ln;
    for (int i = 0; i < 4; i++) begin
      wi = {w[AB-2:2], 2'(i)};
      exp_mem.push_back('{we: 1'b0, addr: wi, data: 16'h0});
      ln[i] = model_rd(int'(wi));
    end
    exp_fill.push_back(ln);
  endtask

  task automatic scramble();
    sdram_addr = $urandom;
    sdram_rw = 1'($urandom);
    data_to_sdram = 16'($urandom);
  endtask

  task automatic do_read(input logic [31:0] a, input int tail);
    push_read(a);
    sdram_req = 1'b1;
    sdram_rw = 1'b1;
    sdram_addr = a;
    data_to_sdram = 16'($urandom);
    wait_for(0, 200, "rd_mem_req");
    scramble();
    wait_for(1, 600, "rd_fill");
    @(negedge clk);
    sdram_req = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [15:0] d,
                          input int hold);
    logic [AB-2:0] w = a[AB-1:1];
    exp_mem.push_back('{we: 1'b1, addr: w, data: d});
    exp_wack++;
    model_mem[int'(w)] = d;
    sdram_req = 1'b1;
    sdram_rw = 1'b0;
    sdram_addr = a;
    data_to_sdram = d;
    wait_for(0, 200, "wr_mem_req");
    scramble();
    wait_for(2, 200, "wr_wack");
    repeat (hold) @(negedge clk);
    sdram_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("wr_wack_count", exp_wack, 0);
  endtask

  initial begin : stimulus
    logic [31:0] a;
    bit          hit;
    repeat (3) @(negedge clk);
    chk("rst_data", data_from_sdram, 16'h0);
    chk("rst_fill", sdram_fill, 1'b0);
    chk("rst_wack", sdram_wack, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    lat_fixed = 2;
    for (int i = 0; i < 4; i++) begin
      store[32'h91C + i] = 16'hA000 + 16'(i);
      model_mem[32'h91C + i] = 16'hA000 + 16'(i);
    end
    do_read(32'h0000_1238, 3);
    do_write(32'h0000_0102, 16'hBEEF, 5);

    do_read(32'h0000_0040, 1);
    do_read(32'h0000_0080, 3);

    spurious = 1'b1;
    repeat (6) @(negedge clk);
    chk("spur_mem_req", mem_req, 1'b0);
    chk("spur_wack", sdram_wack, 1'b0);
    chk("spur_fill", sdram_fill, 1'b0);

    slow_w2 = 1'b1;
    lat_fixed = 1;
    do_read(32'h0000_5A10, 3);
    slow_w2 = 1'b0;

    lat_fixed = 3;
    a = 32'h0000_2340;
    push_read(a);
    sdram_req = 1'b1;
    sdram_rw = 1'b1;
    sdram_addr = a;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      hit = mem_req && mem_addr[1:0] == 2'd2;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout rst_word2: word 2 request not seen, required");
    end
    reset = 1'b0;
    exp_hold = '0;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_mem_we", mem_we, 1'b0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    chk("rst_mid_data", data_from_sdram, 0);
    chk("rst_mid_fill", sdram_fill, 1'b0);
    chk("rst_mid_wack", sdram_wack, 1'b0);
    exp_mem.delete();
    exp_fill.delete();
    repeat (2) @(negedge clk);
    push_read(a);
    reset = 1'b1;
    wait_for(1, 600, "rst_refill");
    @(negedge clk);
    sdram_req = 1'b0;
    repeat (3) @(negedge clk);

    lat_fixed = -1;
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      a[25:7] = 19'h01234;
      if ($urandom_range(0, 1) == 1) begin
        a[2:0] = 3'b000;
        do_read(a, int'($urandom_range(1, 4)));
      end else begin
        do_write(a, 16'($urandom), int'($urandom_range(0, 4)));
      end
    end

    repeat (10) @(negedge clk);
    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("fill_queue_drained", exp_fill.size(), 0);
    chk("wack_drained", exp_wack, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
